// File: rtl/centertrack.sv
// rtl/centertrack.sv - smoothed object-center tracker with swipe gesture detection
//
// Samples the detected center a fixed delay after each frame ends. The samples
// are exponentially smoothed, a lost track is reported after a run of empty
// frames, and swipes are recognised from the displacement against a moving
// anchor point.
//
// Ports:
//   iClk         in   1   pixel clock
//   iRst_n       in   1   asynchronous active-low reset
//   iFrameValid  in   1   frame-valid of the stream feeding the center detector
//   iXCenter     in  12   detected X center, unsigned
//   iYCenter     in  12   detected Y center, unsigned
//   oX           out 12   smoothed X center
//   oY           out 12   smoothed Y center
//   oValid       out  1   a track is held (TRACK or HOLD)
//   oLost        out  1   one-cycle pulse when the track is dropped
//   oGesture     out  3   last gesture: 1 right, 2 left, 3 down, 4 up, 0 none
//   oGestureStb  out  1   one-cycle strobe, oGesture carries a new code

module centertrack #(
    parameter int SAMPLE_DELAY = 40,
    parameter int ALPHA_SHIFT  = 2,
    parameter int LOST_FRAMES  = 4,
    parameter int SWIPE_DIST   = 64,
    parameter int SWIPE_FRAMES = 8
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iFrameValid,
    input  logic [11:0] iXCenter,
    input  logic [11:0] iYCenter,
    output logic [11:0] oX,
    output logic [11:0] oY,
    output logic        oValid,
    output logic        oLost,
    output logic [2:0]  oGesture,
    output logic        oGestureStb
);

    localparam int CNT_W = (SAMPLE_DELAY < 2) ? 1 : $clog2(SAMPLE_DELAY + 1);
    localparam logic [CNT_W-1:0] DELAY_INIT = CNT_W'(SAMPLE_DELAY);
    localparam logic [3:0]       LOST_LIM   = 4'(LOST_FRAMES);
    localparam logic [3:0]       WIN_LIM    = 4'(SWIPE_FRAMES);
    localparam logic [12:0]      SWIPE_LIM  = 13'(SWIPE_DIST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } trackState_e;

    trackState_e state;
    trackState_e nextState;

    // Frame-end detection and sample delay counter
    logic             prevFv;
    logic             counting;
    logic [CNT_W-1:0] sampleCnt;
    logic             frameEnd;
    logic             sampleEvt;
    logic             present;

    // Track bookkeeping
    logic [11:0] anchorX;
    logic [11:0] anchorY;
    logic [3:0]  missCnt;
    logic [3:0]  winCnt;
    logic [3:0]  missNext;
    logic [3:0]  winNext;
    logic        gestChk;
    logic [11:0] smoothX;
    logic [11:0] smoothY;

    // Gesture evaluation against the anchor
    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic [12:0]        dxAbs;
    logic [12:0]        dyAbs;
    logic [2:0]         gestCode;

    // oX + ((target - oX) >>> ALPHA_SHIFT) in 14-bit signed, clamped to 12 bits
    function automatic logic [11:0] smooth(input logic [11:0] cur, input logic [11:0] tgt);
        logic signed [13:0] diff;
        logic signed [13:0] stepVal;
        logic signed [13:0] sum;
        diff    = $signed({2'b00, tgt}) - $signed({2'b00, cur});
        stepVal = diff >>> ALPHA_SHIFT;
        sum     = $signed({2'b00, cur}) + stepVal;
        if (sum < 14'sd0) begin
            return 12'd0;
        end else if (sum > 14'sd4095) begin
            return 12'd4095;
        end else begin
            return sum[11:0];
        end
    endfunction

    assign frameEnd  = prevFv & ~iFrameValid;
    // A frame end in the same cycle as a pending sample wins: the interrupted
    // frame is never sampled.
    assign sampleEvt = counting && (sampleCnt == '0) && !frameEnd;
    assign present   = (iXCenter != 12'd0) || (iYCenter != 12'd0);
    assign missNext  = missCnt + 4'd1;
    assign winNext   = winCnt + 4'd1;
    assign smoothX   = smooth(oX, iXCenter);
    assign smoothY   = smooth(oY, iYCenter);

    assign dx    = $signed({1'b0, oX}) - $signed({1'b0, anchorX});
    assign dy    = $signed({1'b0, oY}) - $signed({1'b0, anchorY});
    assign dxAbs = dx[12] ? $unsigned(-dx) : $unsigned(dx);
    assign dyAbs = dy[12] ? $unsigned(-dy) : $unsigned(dy);

    // X displacement takes priority over Y
    always_comb begin
        gestCode = 3'd0;
        if (dxAbs >= SWIPE_LIM) begin
            gestCode = dx[12] ? 3'd2 : 3'd1;
        end else if (dyAbs >= SWIPE_LIM) begin
            gestCode = dy[12] ? 3'd4 : 3'd3;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prevFv    <= 1'b0;
            counting  <= 1'b0;
            sampleCnt <= '0;
        end else begin
            prevFv <= iFrameValid;
            if (frameEnd) begin
                counting  <= 1'b1;
                sampleCnt <= DELAY_INIT;
            end else if (counting) begin
                if (sampleCnt == '0) begin
                    counting <= 1'b0;
                end else begin
                    sampleCnt <= sampleCnt - CNT_W'(1);
                end
            end
        end
    end

    // State register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: transitions happen only on sample events
    always_comb begin
        nextState = state;
        if (sampleEvt) begin
            case (state)
                IDLE: begin
                    if (present) begin
                        nextState = TRACK;
                    end
                end
                TRACK, HOLD: begin
                    if (present) begin
                        nextState = TRACK;
                    end else if (missNext == LOST_LIM) begin
                        nextState = IDLE;
                    end else begin
                        nextState = HOLD;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        oValid = (state == TRACK) || (state == HOLD);
    end

    // Position, anchor and gesture datapath
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oX          <= 12'd0;
            oY          <= 12'd0;
            oLost       <= 1'b0;
            oGesture    <= 3'd0;
            oGestureStb <= 1'b0;
            anchorX     <= 12'd0;
            anchorY     <= 12'd0;
            missCnt     <= 4'd0;
            winCnt      <= 4'd0;
            gestChk     <= 1'b0;
        end else begin
            oLost       <= 1'b0;
            oGestureStb <= 1'b0;
            gestChk     <= 1'b0;
            if (sampleEvt) begin
                if (state == IDLE) begin
                    if (present) begin
                        oX      <= iXCenter;
                        oY      <= iYCenter;
                        anchorX <= iXCenter;
                        anchorY <= iYCenter;
                        winCnt  <= 4'd0;
                        missCnt <= 4'd0;
                    end
                end else if (present) begin
                    oX      <= smoothX;
                    oY      <= smoothY;
                    missCnt <= 4'd0;
                    // Gesture is judged next cycle on the updated position
                    gestChk <= 1'b1;
                end else if (missNext == LOST_LIM) begin
                    oLost    <= 1'b1;
                    oGesture <= 3'd0;
                    anchorX  <= 12'd0;
                    anchorY  <= 12'd0;
                    missCnt  <= 4'd0;
                    winCnt   <= 4'd0;
                end else begin
                    missCnt <= missNext;
                end
            end else if (gestChk) begin
                if (gestCode != 3'd0) begin
                    oGesture    <= gestCode;
                    oGestureStb <= 1'b1;
                    anchorX     <= oX;
                    anchorY     <= oY;
                    winCnt      <= 4'd0;
                end else if (winNext == WIN_LIM) begin
                    // Window expired: slow drift re-anchors instead of firing
                    anchorX <= oX;
                    anchorY <= oY;
                    winCnt  <= 4'd0;
                end else begin
                    winCnt <= winNext;
                end
            end
        end
    end

endmodule

// File: tb/tb_centertrack.sv
// tb/tb_centertrack.sv - self-checking bench for centertrack

module tb_centertrack;

    localparam int SD    = 40;
    localparam int ALPHA = 2;
    localparam int LOSTN = 4;
    localparam int SWD   = 64;
    localparam int WINF  = 8;

    logic        iClk;
    logic        iRst_n;
    logic        iFrameValid;
    logic [11:0] iXCenter;
    logic [11:0] iYCenter;
    logic [11:0] oX;
    logic [11:0] oY;
    logic        oValid;
    logic        oLost;
    logic [2:0]  oGesture;
    logic        oGestureStb;

    centertrack dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iFrameValid (iFrameValid),
        .iXCenter    (iXCenter),
        .iYCenter    (iYCenter),
        .oX          (oX),
        .oY          (oY),
        .oValid      (oValid),
        .oLost       (oLost),
        .oGesture    (oGesture),
        .oGestureStb (oGestureStb)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;
    int stbCnt  = 0;
    int lostCnt = 0;

    always @(negedge iClk) begin
        if (oGestureStb) stbCnt++;
        if (oLost) lostCnt++;
    end

    // Behavioural reference: track state 0 idle, 1 track, 2 hold
    int mSt, mX, mY, mAx, mAy, mMiss, mWin, mGest;

    typedef struct {
        int x; int y;
        int ex; int ey; int ev; int estb; int ecode; int elost;
    } vec_t;

    vec_t tbl[15];

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic frame(input int hi);
        iFrameValid = 1'b1;
        repeat (hi) step();
        iFrameValid = 1'b0;
    endtask

    task automatic settle();
        repeat (SD + 4) step();
    endtask

    function automatic int floorDiv(input int d, input int q);
        if (d >= 0) return d / q;
        return -((-d + q - 1) / q);
    endfunction

    function automatic int clampI(input int v);
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

    function automatic int absI(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic modelReset();
        mSt = 0; mX = 0; mY = 0; mAx = 0; mAy = 0; mMiss = 0; mWin = 0; mGest = 0;
    endtask

    task automatic modelSample(input int x, input int y, output int stb, output int lost);
        int dxm, dym, code;
        stb = 0;
        lost = 0;
        if (x == 0 && y == 0) begin
            if (mSt != 0) begin
                mMiss++;
                if (mMiss == LOSTN) begin
                    lost = 1;
                    mSt = 0; mAx = 0; mAy = 0; mWin = 0; mMiss = 0; mGest = 0;
                end else begin
                    mSt = 2;
                end
            end
        end else if (mSt == 0) begin
            mX = x; mY = y; mAx = x; mAy = y; mWin = 0; mMiss = 0; mSt = 1;
        end else begin
            mX = clampI(mX + floorDiv(x - mX, 1 << ALPHA));
            mY = clampI(mY + floorDiv(y - mY, 1 << ALPHA));
            mMiss = 0;
            mSt = 1;
            dxm = mX - mAx;
            dym = mY - mAy;
            code = 0;
            if (absI(dxm) >= SWD) code = (dxm > 0) ? 1 : 2;
            else if (absI(dym) >= SWD) code = (dym > 0) ? 3 : 4;
            if (code != 0) begin
                mGest = code; stb = 1; mAx = mX; mAy = mY; mWin = 0;
            end else begin
                mWin++;
                if (mWin == WINF) begin
                    mAx = mX; mAy = mY; mWin = 0;
                end
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int s0, l0, es, el, x, y, r;
        string nm;

        tbl[0]  = '{100, 100, 100, 100, 1, 0, 0, 0};
        tbl[1]  = '{200, 100, 125, 100, 1, 0, 0, 0};
        tbl[2]  = '{200, 100, 143, 100, 1, 0, 0, 0};
        tbl[3]  = '{200, 100, 157, 100, 1, 0, 0, 0};
        tbl[4]  = '{400, 100, 217, 100, 1, 1, 1, 0};
        tbl[5]  = '{0,   0,   217, 100, 1, 0, 1, 0};
        tbl[6]  = '{0,   0,   217, 100, 1, 0, 1, 0};
        tbl[7]  = '{0,   0,   217, 100, 1, 0, 1, 0};
        tbl[8]  = '{0,   0,   217, 100, 0, 0, 0, 1};
        tbl[9]  = '{200, 100, 200, 100, 1, 0, 0, 0};
        tbl[10] = '{200, 400, 200, 175, 1, 1, 3, 0};
        tbl[11] = '{200, 0,   200, 131, 1, 0, 3, 0};
        tbl[12] = '{200, 0,   200, 98,  1, 1, 4, 0};
        tbl[13] = '{50,  98,  162, 98,  1, 0, 4, 0};
        tbl[14] = '{50,  98,  134, 98,  1, 1, 2, 0};

        iRst_n = 1'b0;
        iFrameValid = 1'b0;
        iXCenter = 12'd0;
        iYCenter = 12'd0;
        modelReset();
        repeat (3) step();
        chk("reset_oX", int'(oX), 0);
        chk("reset_oY", int'(oY), 0);
        chk("reset_valid", int'(oValid), 0);
        chk("reset_lost", int'(oLost), 0);
        chk("reset_gesture", int'(oGesture), 0);
        chk("reset_stb", int'(oGestureStb), 0);
        iRst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            iXCenter = 12'(tbl[i].x);
            iYCenter = 12'(tbl[i].y);
            s0 = stbCnt;
            l0 = lostCnt;
            frame(3);
            settle();
            chk($sformatf("tbl%0d_oX", i), int'(oX), tbl[i].ex);
            chk($sformatf("tbl%0d_oY", i), int'(oY), tbl[i].ey);
            chk($sformatf("tbl%0d_valid", i), int'(oValid), tbl[i].ev);
            chk($sformatf("tbl%0d_stb", i), stbCnt - s0, tbl[i].estb);
            chk($sformatf("tbl%0d_gesture", i), int'(oGesture), tbl[i].ecode);
            chk($sformatf("tbl%0d_lost", i), lostCnt - l0, tbl[i].elost);
        end

        // Reset pulsed mid-count while tracking
        iXCenter = 12'd700;
        iYCenter = 12'd700;
        frame(3);
        repeat (10) step();
        #2 iRst_n = 1'b0;
        #1;
        chk("midrst_oX", int'(oX), 0);
        chk("midrst_oY", int'(oY), 0);
        chk("midrst_valid", int'(oValid), 0);
        chk("midrst_gesture", int'(oGesture), 0);
        chk("midrst_stb", int'(oGestureStb), 0);
        chk("midrst_lost", int'(oLost), 0);
        step();
        step();
        iRst_n = 1'b1;
        modelReset();
        repeat (SD + 10) step();
        chk("midrst_nosample_valid", int'(oValid), 0);
        chk("midrst_nosample_oX", int'(oX), 0);
        iXCenter = 12'd300;
        iYCenter = 12'd300;
        frame(3);
        settle();
        modelSample(300, 300, es, el);
        chk("postrst_oX", int'(oX), 300);
        chk("postrst_valid", int'(oValid), 1);

        // Second frame end 10 cycles after the first: single sample, timed from the second
        iXCenter = 12'd700;
        iYCenter = 12'd300;
        s0 = stbCnt;
        frame(3);
        repeat (7) step();
        frame(3);
        repeat (SD + 1) step();
        chk("dbl_before_oX", int'(oX), 300);
        step();
        chk("dbl_after_oX", int'(oX), 400);
        repeat (SD + 20) step();
        chk("dbl_once_oX", int'(oX), 400);
        modelSample(700, 300, es, el);
        chk("dbl_stb", stbCnt - s0, es);
        chk("dbl_gesture", int'(oGesture), mGest);

        // Randomised frames against the reference model
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 7));
            if (r < 2) begin
                x = 0; y = 0;
            end else if (r == 2) begin
                x = int'($urandom_range(0, 4095));
                y = int'($urandom_range(0, 4095));
            end else begin
                x = clampI(mX + int'($urandom_range(0, 320)) - 160);
                y = clampI(mY + int'($urandom_range(0, 320)) - 160);
            end
            iXCenter = 12'(x);
            iYCenter = 12'(y);
            s0 = stbCnt;
            l0 = lostCnt;
            if ($urandom_range(0, 7) == 0) begin
                frame(int'($urandom_range(1, 5)));
                repeat (int'($urandom_range(1, SD - 10))) step();
            end
            frame(int'($urandom_range(1, 5)));
            settle();
            modelSample(x, y, es, el);
            nm = $sformatf("rnd%0d", i);
            chk({nm, "_oX"}, int'(oX), mX);
            chk({nm, "_oY"}, int'(oY), mY);
            chk({nm, "_valid"}, int'(oValid), (mSt != 0) ? 1 : 0);
            chk({nm, "_gesture"}, int'(oGesture), mGest);
            chk({nm, "_stb"}, stbCnt - s0, es);
            chk({nm, "_lost"}, lostCnt - l0, el);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
